tansig_arbiter: RTL



---
 rtl/tansig_arbiter_if.sv | 28 ++
 rtl/tansig_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tansig_arbiter_if.sv
// Request/response and activation-unit bundle shared by the tansig arbiter
// and whatever sits around it (layer controllers plus the activation datapath).
interface tansig_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  u_in_valid;
  logic [WIDTH-1:0]      u_in_data;
  logic                  u_out_valid;
  logic [WIDTH-1:0]      u_out_data;

  // The arbiter side: takes operands, drives the unit, returns results.
  modport slave (
    input  req_valid, req_data, u_out_valid, u_out_data,
    output req_ready, rsp_valid, rsp_data, u_in_valid, u_in_data
  );

  // The environment side: requesters plus the activation unit.
  modport master (
    output req_valid, req_data, u_out_valid, u_out_data,
    input  req_ready, rsp_valid, rsp_data, u_in_valid, u_in_data
  );
endinterface

// File: rtl/tansig_arbiter.sv
// Round-robin scheduler in front of one shared, fixed-latency tansig unit.
// Each issued operand carries its requester tag down a LAT-deep pipeline
// that lines up with the unit output, so results go back to their owner.
module tansig_arbiter #(
  parameter int NREQ  = 3,
  parameter int LAT   = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  tansig_arbiter_if.slave  bus,
  output logic             busy,
  output logic             err
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(LAT + 2);

  logic [TW-1:0]    prio_reg;
  logic             u_in_valid_reg;
  logic [WIDTH-1:0] u_in_data_reg;
  logic [TW-1:0]    u_in_tag_reg;
  logic [NREQ-1:0]  rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [GW-1:0]    guard_reg;
  logic             err_reg;

  wire  [NREQ-1:0]  prio_mask;
  logic [NREQ-1:0]  req_hi;
  logic [NREQ-1:0]  grant_raw;
  logic [NREQ-1:0]  grant;
  wire  [TW-1:0]    grant_idx;
  wire  [WIDTH-1:0] data_chain [NREQ+1];
  logic             transfer;
  wire  [LAT-1:0]   tag_valid_vec;
  logic             last_valid;
  logic [TW-1:0]    last_tag;

  genvar gi, gb;

  // Requesters at or above prio form the first search window; if none of
  // them is valid the search wraps to the lowest valid index overall.
  for (gi = 0; gi < NREQ; gi++) begin : g_mask
    assign prio_mask[gi] = (prio_reg <= TW'(gi));
  end

  assign req_hi    = bus.req_valid & prio_mask;
  assign grant_raw = (|req_hi) ? (req_hi & (~req_hi + NREQ'(1)))
                               : (bus.req_valid & (~bus.req_valid + NREQ'(1)));
  assign grant     = rst ? '0 : grant_raw;
  assign transfer  = |grant;
  assign bus.req_ready = grant;

  // One-hot grant to binary index, one OR-reduction per index bit.
  for (gb = 0; gb < TW; gb++) begin : g_enc
    wire [NREQ-1:0] sel_mask;
    for (gi = 0; gi < NREQ; gi++) begin : g_sel
      assign sel_mask[gi] = 1'(((gi >> gb) & 1));
    end
    assign grant_idx[gb] = |(grant & sel_mask);
  end

  // AND-OR mux of the granted operand.
  assign data_chain[0] = '0;
  for (gi = 0; gi < NREQ; gi++) begin : g_dmux
    assign data_chain[gi+1] = data_chain[gi]
                            | (bus.req_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}});
  end

  // Issue register and round-robin pointer update on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_in_valid_reg <= 1'b0;
      u_in_data_reg  <= '0;
      u_in_tag_reg   <= '0;
      prio_reg       <= '0;
    end else if (transfer) begin
      u_in_valid_reg <= 1'b1;
      u_in_data_reg  <= data_chain[NREQ];
      u_in_tag_reg   <= grant_idx;
      prio_reg       <= (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
    end else begin
      u_in_valid_reg <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 samples the issue register, so the last stage is
  // valid in exactly the cycle the unit presents that operand's result.
  for (gi = 0; gi < LAT; gi++) begin : g_tag
    logic          stage_valid_reg;
    logic [TW-1:0] stage_tag_reg;
    logic          in_valid;
    logic [TW-1:0] in_tag;
    if (gi == 0) begin : g_head
      assign in_valid = u_in_valid_reg;
      assign in_tag   = u_in_tag_reg;
    end else begin : g_tail
      assign in_valid = g_tag[gi-1].stage_valid_reg;
      assign in_tag   = g_tag[gi-1].stage_tag_reg;
    end
    // Shift one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_valid_reg <= 1'b0;
        stage_tag_reg   <= '0;
      end else begin
        stage_valid_reg <= in_valid;
        stage_tag_reg   <= in_tag;
      end
    end
    assign tag_valid_vec[gi] = stage_valid_reg;
  end

  assign last_valid = g_tag[LAT-1].stage_valid_reg;
  assign last_tag   = g_tag[LAT-1].stage_tag_reg;

  // Response register: route the unit result to the tagged requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else if (last_valid && bus.u_out_valid) begin
      rsp_valid_reg <= NREQ'(1) << last_tag;
      rsp_data_reg  <= bus.u_out_data;
    end else begin
      rsp_valid_reg <= '0;
    end
  end

  // Guard window: the unit has no reset, so whatever drains out of it in the
  // first LAT+1 cycles after reset is not trusted for mismatch checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_reg <= GW'(LAT + 1);
    end else if (guard_reg != '0) begin
      guard_reg <= guard_reg - GW'(1);
    end
  end

  // Sticky flag for a unit valid that disagrees with the expected tag valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((guard_reg == '0) && (bus.u_out_valid != last_valid)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.u_in_valid = u_in_valid_reg;
  assign bus.u_in_data  = u_in_data_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign busy = u_in_valid_reg | (|tag_valid_vec) | (|rsp_valid_reg);
  assign err  = err_reg;
endmodule
